// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and FSM state encoding.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned word_size            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_rcvr_if.sv
// Host-side and line-side signal bundle of the UART receiver.
interface uart_rcvr_if;
    import uart_pkg::*;

    logic                 Serial_in;
    logic                 read_not_ready_in;
    logic [word_size-1:0] RCV_datareg;
    logic                 read_not_ready_out;
    logic                 Error1;
    logic                 Error2;
    logic                 Error3;

    modport master (
        output Serial_in,
        output read_not_ready_in,
        input  RCV_datareg,
        input  read_not_ready_out,
        input  Error1,
        input  Error2,
        input  Error3
    );

    modport slave (
        input  Serial_in,
        input  read_not_ready_in,
        output RCV_datareg,
        output read_not_ready_out,
        output Error1,
        output Error2,
        output Error3
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, synchronous reset to ResetVal.
module uart_sync2 #(
    parameter bit ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rcvr.sv
// UART receiver: 8N1 framing (8E1 when UART_RCVR_PARITY_EN is defined), ready/read handshake,
// overrun / framing / parity error pulses.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input logic        Clock,
    input logic        rst,
    uart_rcvr_if.slave bus
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic                 s;
    logic                 s_prev_q;
    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [word_size-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 stop_ok_q, stop_ok_d;
    logic [word_size-1:0] datareg_q;
    logic                 rnr_q;
    logic                 err1_q, err2_q;
    logic                 frame_good;

    uart_sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i(Clock),
        .rst_i(rst),
        .d_i  (bus.Serial_in),
        .q_o  (s)
    );

`ifdef UART_RCVR_PARITY_EN
    logic par_ok_q, par_ok_d;
    logic err3_q;
    assign frame_good = stop_ok_q & par_ok_q;
`else
    assign frame_good = stop_ok_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        stop_ok_d = stop_ok_q;
`ifdef UART_RCVR_PARITY_EN
        par_ok_d  = par_ok_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (s_prev_q && !s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    shift_d   = {s, shift_q[word_size-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RCVR_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RCVR_PARITY_EN
            StParity: begin
                if (cnt_q == CntLast) begin
                    cnt_d    = '0;
                    par_ok_d = (s == ^shift_q);
                    state_d  = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    stop_ok_d = s;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            stop_ok_q <= 1'b0;
            s_prev_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            stop_ok_q <= stop_ok_d;
            s_prev_q  <= s;
        end
    end

    // Frame outcome is committed one edge after the stop sample; errors pulse on that edge.
    always_ff @(posedge Clock) begin
        if (rst) begin
            datareg_q <= '0;
            rnr_q     <= 1'b0;
            err1_q    <= 1'b0;
            err2_q    <= 1'b0;
        end else begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
            if (bus.read_not_ready_in) rnr_q <= 1'b0;
            if (done_q) begin
                if (frame_good) begin
                    datareg_q <= shift_q;
                    rnr_q     <= 1'b1;
                    err1_q    <= rnr_q & ~bus.read_not_ready_in;
                end
                err2_q <= ~stop_ok_q;
            end
        end
    end

`ifdef UART_RCVR_PARITY_EN
    always_ff @(posedge Clock) begin
        if (rst) begin
            par_ok_q <= 1'b1;
            err3_q   <= 1'b0;
        end else begin
            par_ok_q <= par_ok_d;
            err3_q   <= done_q & ~par_ok_q;
        end
    end
    assign bus.Error3 = err3_q;
`else
    assign bus.Error3 = 1'b0;
`endif

    assign bus.RCV_datareg        = datareg_q;
    assign bus.read_not_ready_out = rnr_q;
    assign bus.Error1             = err1_q;
    assign bus.Error2             = err2_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed self-checking bench for uart_rcvr at 8 clocks per bit.
module tb_uart_rcvr;
    import uart_pkg::*;

    localparam int N = 8;

    logic clk;
    logic rst;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   e1_cnt    = 0;
    int   e2_cnt    = 0;
    int   e3_cnt    = 0;
    int   rise_cnt  = 0;
    logic rnr_prev  = 1'b0;

    uart_rcvr_if bus ();

    uart_rcvr #(
        .CLKS_PER_BIT(N)
    ) dut (
        .Clock(clk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.Error1) e1_cnt++;
        if (bus.Error2) e2_cnt++;
        if (bus.Error3) e3_cnt++;
        if (bus.read_not_ready_out && !rnr_prev) rise_cnt++;
        rnr_prev = bus.read_not_ready_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.Serial_in = b;
        tick(N);
    endtask

    // Returns #1 after the edge where the frame outcome lands on the outputs.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, input logic rd_end);
        logic [7:0] d;
        d = data;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RCVR_PARITY_EN
        drive_bit(par_bit);
`else
        if (par_bit === 1'bx) tick(0);
`endif
        bus.Serial_in = stop_bit;
        tick(N - 1);
        bus.read_not_ready_in = rd_end;
        tick(1);
        bus.read_not_ready_in = 1'b0;
    endtask

    task automatic do_read();
        bus.read_not_ready_in = 1'b1;
        tick(1);
        bus.read_not_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        bus.Serial_in         = 1'b1;
        bus.read_not_ready_in = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        total_cnt++;
        if (bus.RCV_datareg !== 8'h00 || bus.read_not_ready_out !== 1'b0 ||
            bus.Error1 !== 1'b0 || bus.Error2 !== 1'b0 || bus.Error3 !== 1'b0)
            $display("FAIL reset_outputs: got data=%h rnr=%b e=%b%b%b, want all 0",
                     bus.RCV_datareg, bus.read_not_ready_out, bus.Error1, bus.Error2, bus.Error3);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== StIdle) $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        else pass_cnt++;
        tick(2);
    endtask

    task automatic test_clean();
        logic [7:0] b;
        int r0, e10, e20;
        r0 = rise_cnt; e10 = e1_cnt; e20 = e2_cnt;
        for (int i = 0; i < 5; i++) begin
            b = 8'h41 + 8'(i);
            send_frame(b, 1'b1, ^b, 1'b0);
            total_cnt++;
            if (bus.RCV_datareg !== b || bus.read_not_ready_out !== 1'b1)
                $display("FAIL clean_byte%0d: got data=%h rnr=%b want data=%h rnr=1",
                         i, bus.RCV_datareg, bus.read_not_ready_out, b);
            else pass_cnt++;
            do_read();
            total_cnt++;
            if (bus.read_not_ready_out !== 1'b0)
                $display("FAIL clean_read%0d: got rnr=%b want 0", i, bus.read_not_ready_out);
            else pass_cnt++;
        end
        total_cnt++;
        if (rise_cnt - r0 !== 5) $display("FAIL clean_rises: got %0d want 5", rise_cnt - r0);
        else pass_cnt++;
        total_cnt++;
        if (e1_cnt - e10 !== 0 || e2_cnt - e20 !== 0)
            $display("FAIL clean_errors: got e1=%0d e2=%0d want 0 0", e1_cnt - e10, e2_cnt - e20);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int e10;
        e10 = e1_cnt;
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (bus.RCV_datareg !== 8'h42 || bus.Error1 !== 1'b1 || bus.read_not_ready_out !== 1'b1)
            $display("FAIL overrun: got data=%h e1=%b rnr=%b want data=42 e1=1 rnr=1",
                     bus.RCV_datareg, bus.Error1, bus.read_not_ready_out);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (bus.Error1 !== 1'b0 || e1_cnt - e10 !== 1)
            $display("FAIL overrun_pulse: got e1=%b pulses=%0d want 0 and 1",
                     bus.Error1, e1_cnt - e10);
        else pass_cnt++;
        do_read();
    endtask

    task automatic test_back_to_back();
        int e10;
        e10 = e1_cnt;
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h43, 1'b1, 1'b1, 1'b1);
        total_cnt++;
        if (bus.RCV_datareg !== 8'h43 || bus.read_not_ready_out !== 1'b1 || e1_cnt - e10 !== 0)
            $display("FAIL load_and_read: got data=%h rnr=%b e1_pulses=%0d want 43 1 0",
                     bus.RCV_datareg, bus.read_not_ready_out, e1_cnt - e10);
        else pass_cnt++;
        do_read();
        do_read();
        total_cnt++;
        if (bus.read_not_ready_out !== 1'b0 || bus.RCV_datareg !== 8'h43)
            $display("FAIL idle_read: got rnr=%b data=%h want 0 43",
                     bus.read_not_ready_out, bus.RCV_datareg);
        else pass_cnt++;
    endtask

    task automatic test_framing();
        int e20;
        e20 = e2_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (bus.Error2 !== 1'b1 || bus.RCV_datareg !== 8'h43 || bus.read_not_ready_out !== 1'b0)
            $display("FAIL framing: got e2=%b data=%h rnr=%b want 1 43 0",
                     bus.Error2, bus.RCV_datareg, bus.read_not_ready_out);
        else pass_cnt++;
        tick(120);
        total_cnt++;
        if (e2_cnt - e20 !== 1 || dut.state_q !== StIdle)
            $display("FAIL framing_norestart: got e2_pulses=%0d state=%0d want 1 IDLE",
                     e2_cnt - e20, dut.state_q);
        else pass_cnt++;
        bus.Serial_in = 1'b1;
        tick(4);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (bus.RCV_datareg !== 8'h5A || bus.read_not_ready_out !== 1'b1)
            $display("FAIL framing_recover: got data=%h rnr=%b want 5a 1",
                     bus.RCV_datareg, bus.read_not_ready_out);
        else pass_cnt++;
        do_read();
    endtask

    task automatic test_glitch_reset();
        int e10, e20;
        e10 = e1_cnt; e20 = e2_cnt;
        bus.Serial_in = 1'b0;
        tick(2);
        bus.Serial_in = 1'b1;
        tick(100);
        total_cnt++;
        if (bus.read_not_ready_out !== 1'b0 || bus.RCV_datareg !== 8'h5A ||
            e2_cnt - e20 !== 0 || dut.state_q !== StIdle)
            $display("FAIL glitch: got rnr=%b data=%h e2_pulses=%0d state=%0d want 0 5a 0 IDLE",
                     bus.read_not_ready_out, bus.RCV_datareg, e2_cnt - e20, dut.state_q);
        else pass_cnt++;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        total_cnt++;
        if (dut.state_q !== StData) $display("FAIL midframe_state: got %0d want DATA", dut.state_q);
        else pass_cnt++;
        rst = 1'b1;
        bus.Serial_in = 1'b1;
        tick(1);
        total_cnt++;
        if (dut.state_q !== StIdle) $display("FAIL midframe_reset: got %0d want IDLE", dut.state_q);
        else pass_cnt++;
        rst = 1'b0;
        tick(100);
        total_cnt++;
        if (bus.read_not_ready_out !== 1'b0 || e1_cnt - e10 !== 0 || e2_cnt - e20 !== 0)
            $display("FAIL midframe_quiet: got rnr=%b e1=%0d e2=%0d want 0 0 0",
                     bus.read_not_ready_out, e1_cnt - e10, e2_cnt - e20);
        else pass_cnt++;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (bus.RCV_datareg !== 8'hA5 || bus.read_not_ready_out !== 1'b1)
            $display("FAIL after_reset_a5: got data=%h rnr=%b want a5 1",
                     bus.RCV_datareg, bus.read_not_ready_out);
        else pass_cnt++;
        do_read();
    endtask

`ifdef UART_RCVR_PARITY_EN
    task automatic test_parity();
        send_frame(8'h41, 1'b1, 1'b0, 1'b0);
        total_cnt++;
        if (bus.RCV_datareg !== 8'h41 || bus.read_not_ready_out !== 1'b1 || bus.Error3 !== 1'b0)
            $display("FAIL parity_good: got data=%h rnr=%b e3=%b want 41 1 0",
                     bus.RCV_datareg, bus.read_not_ready_out, bus.Error3);
        else pass_cnt++;
        do_read();
        send_frame(8'h41, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (bus.Error3 !== 1'b1 || bus.read_not_ready_out !== 1'b0)
            $display("FAIL parity_bad: got e3=%b rnr=%b want 1 0",
                     bus.Error3, bus.read_not_ready_out);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (bus.Error3 !== 1'b0) $display("FAIL parity_pulse: got e3=%b want 0", bus.Error3);
        else pass_cnt++;
    endtask
`else
    task automatic test_no_parity();
        total_cnt++;
        if (e3_cnt !== 0) $display("FAIL error3_tied: got %0d pulses want 0", e3_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_overrun();
        test_back_to_back();
        test_framing();
        test_glitch_reset();
`ifdef UART_RCVR_PARITY_EN
        test_parity();
`else
        test_no_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
